// File: rtl/spi_pwm_pkg.sv
// Shared definitions for the SPI-controlled PWM block:
// command byte layout, time base constant and protocol states.
package spi_pwm_pkg;

    localparam int CMD_CH = 0;
    localparam int CMD_CH_W = 4;
    localparam int CMD_SEL = 4;
    localparam int CMD_WR = 5;
    localparam int USEC_PER_SEC = 1000000;

    typedef enum logic [1:0] {
        IDLE,
        BYTE_LO,
        BYTE_HI
    } state_t;

endpackage

// File: rtl/spi_pwm_ctrl_pwm_core.sv
// PWM core: microsecond prescaler, phase accumulator for the period,
// and duty compare driving a registered output pin.
import spi_pwm_pkg::*;

module pwm_core #(
    parameter int CLK_HZ = 12000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] freq,
    input  logic [15:0] duty,
    output logic        pin
);

    localparam int DIV = CLK_HZ / USEC_PER_SEC;
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] DIV_LAST = PW'(DIV - 1);

    logic [PW-1:0] pre;
    logic          tick;
    logic [19:0]   acc;
    logic [15:0]   usec_cnt;
    logic [20:0]   sum;
    logic          wrap;
    logic [15:0]   usec_next;

    assign tick = (pre == DIV_LAST);
    // One extra bit: acc + freq can exceed the 20-bit range before wrapping
    assign sum = {1'b0, acc} + {5'd0, freq};
    assign wrap = (sum >= 21'(USEC_PER_SEC));

    always_comb begin
        usec_next = usec_cnt;
        if (wrap) begin
            usec_next = '0;
        end else if (usec_cnt != 16'hFFFF) begin
            usec_next = usec_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre      <= '0;
            acc      <= '0;
            usec_cnt <= '0;
            pin      <= 1'b0;
        end else begin
            pre <= tick ? '0 : pre + PW'(1);
            if (tick) begin
                if (freq == 16'd0) begin
                    pin <= 1'b0;
                end else begin
                    acc      <= wrap ? 20'(sum - 21'(USEC_PER_SEC)) : sum[19:0];
                    usec_cnt <= usec_next;
                    pin      <= (usec_next < duty);
                end
            end
        end
    end

endmodule

// File: rtl/spi_pwm_ctrl.sv
// SPI mode-0 slave with a small command FSM that reads and writes
// the PWM frequency and duty registers, plus the PWM output core.
import spi_pwm_pkg::*;

module spi_pwm_ctrl #(
    parameter int          CLK_HZ     = 12000000,
    parameter logic [15:0] FREQ_RESET = 16'd400
) (
    input  logic clk,
    input  logic rst,
    input  logic sclk,
    input  logic mosi,
    output logic miso,
    input  logic ss,
    output logic pwm_pin
);

    logic [2:0]  sclk_q;
    logic [1:0]  mosi_q;
    logic [1:0]  ss_q;
    logic        sclk_rise;
    logic        sclk_fall;
    logic [2:0]  bit_cnt;
    logic [6:0]  rx_sr;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic [6:0]  tx_sr;
    state_t      state;
    logic [3:0]  ch;
    logic        sel;
    logic        wr;
    logic [7:0]  lo_byte;
    logic [15:0] freq;
    logic [15:0] duty;
    logic        rd_sel;
    logic        rd_ok;
    logic [15:0] rd_reg;
    logic [7:0]  tx_byte;

    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall = ~sclk_q[1] & sclk_q[2];

    // Byte to present next; in IDLE the command is still in rx_byte
    always_comb begin
        rd_sel  = sel;
        rd_ok   = !wr && (ch == 4'd0);
        if (state == IDLE) begin
            rd_sel = rx_byte[CMD_SEL];
            rd_ok  = !rx_byte[CMD_WR] && (rx_byte[CMD_CH +: CMD_CH_W] == 4'd0);
        end
        rd_reg  = rd_sel ? duty : freq;
        tx_byte = 8'h00;
        if (rd_ok) begin
            tx_byte = (state == BYTE_LO) ? rd_reg[15:8] : rd_reg[7:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_q   <= '0;
            mosi_q   <= '0;
            ss_q     <= '1;
            bit_cnt  <= '0;
            rx_sr    <= '0;
            rx_byte  <= '0;
            rx_valid <= 1'b0;
            tx_sr    <= '0;
            miso     <= 1'b0;
            state    <= IDLE;
            ch       <= '0;
            sel      <= 1'b0;
            wr       <= 1'b0;
            lo_byte  <= '0;
            freq     <= FREQ_RESET;
            duty     <= '0;
        end else begin
            sclk_q   <= {sclk_q[1:0], sclk};
            mosi_q   <= {mosi_q[0], mosi};
            ss_q     <= {ss_q[0], ss};
            rx_valid <= 1'b0;
            if (ss_q[1]) begin
                bit_cnt <= '0;
                state   <= IDLE;
                miso    <= 1'b0;
                tx_sr   <= '0;
            end else begin
                if (sclk_rise) begin
                    rx_sr   <= {rx_sr[5:0], mosi_q[1]};
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        rx_byte  <= {rx_sr, mosi_q[1]};
                        rx_valid <= 1'b1;
                    end
                end
                // The fall after the 8th rise must keep the freshly loaded MSB
                if (sclk_fall && bit_cnt != 3'd0) begin
                    miso  <= tx_sr[6];
                    tx_sr <= {tx_sr[5:0], 1'b0};
                end
                if (rx_valid) begin
                    miso  <= tx_byte[7];
                    tx_sr <= tx_byte[6:0];
                    unique case (state)
                        IDLE: begin
                            ch    <= rx_byte[CMD_CH +: CMD_CH_W];
                            sel   <= rx_byte[CMD_SEL];
                            wr    <= rx_byte[CMD_WR];
                            state <= BYTE_LO;
                        end
                        BYTE_LO: begin
                            lo_byte <= rx_byte;
                            state   <= BYTE_HI;
                        end
                        BYTE_HI: begin
                            if (wr && ch == 4'd0) begin
                                if (sel) begin
                                    duty <= {rx_byte, lo_byte};
                                end else begin
                                    freq <= {rx_byte, lo_byte};
                                end
                            end
                            if (wr) begin
                                ch <= ch + 4'd1;
                            end
                            state <= BYTE_LO;
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

    pwm_core #(
        .CLK_HZ(CLK_HZ)
    ) u_pwm (
        .clk (clk),
        .rst (rst),
        .freq(freq),
        .duty(duty),
        .pin (pwm_pin)
    );

endmodule

// File: tb/tb_spi_pwm_ctrl.sv
// Bench for spi_pwm_ctrl: SPI transactions with a transaction-level
// register model and a per-cycle PWM model compared on every clock.
module tb_spi_pwm_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic sclk = 1'b0;
    logic mosi = 1'b0;
    logic ss = 1'b1;
    logic miso;
    logic pwm_pin;

    always #5 clk = ~clk;

    spi_pwm_ctrl #(
        .CLK_HZ(12000000),
        .FREQ_RESET(16'd400)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .sclk   (sclk),
        .mosi   (mosi),
        .miso   (miso),
        .ss     (ss),
        .pwm_pin(pwm_pin)
    );

    int errors = 0;
    int checks = 0;
    int cyc_fail = 0;

    // Register model and PWM model state
    int m_freq = 400;
    int m_duty = 0;
    int m_acc = 0;
    int m_usec = 0;
    bit m_pin = 1'b0;
    int edges = 0;
    bit cmp_en = 1'b0;
    bit pend = 1'b0;
    bit pend_sel = 1'b0;
    int pend_val = 0;
    int a_nx;
    int u_nx;

    logic [7:0] txq[$];
    logic [7:0] rxq[$];
    int cnt;

    // One microsecond = 12 clocks; each tick advances the period phase by freq
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            edges  <= 0;
            m_acc  <= 0;
            m_usec <= 0;
            m_pin  <= 1'b0;
        end else begin
            edges <= edges + 1;
            if ((edges + 1) % 12 == 0) begin
                if (m_freq == 0) begin
                    m_pin <= 1'b0;
                end else begin
                    a_nx = m_acc + m_freq;
                    u_nx = m_usec;
                    if (a_nx >= 1000000) begin
                        a_nx = a_nx - 1000000;
                        u_nx = 0;
                    end else if (u_nx < 65535) begin
                        u_nx = u_nx + 1;
                    end
                    m_acc  <= a_nx;
                    m_usec <= u_nx;
                    m_pin  <= (u_nx < m_duty);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && cmp_en) begin
            checks++;
            if (pwm_pin !== m_pin) begin
                errors++;
                cyc_fail++;
                if (cyc_fail <= 10)
                    $display("FAIL pwm_cycle t=%0t: pin=%b want %b", $time, pwm_pin, m_pin);
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, got, exp);
        end
    endtask

    task automatic commit();
        if (pend) begin
            if (pend_sel) m_duty = pend_val;
            else m_freq = pend_val;
            pend = 1'b0;
        end
    endtask

    task automatic align();
        do @(negedge clk); while (edges % 12 != 0);
    endtask

    // 24-clock sclk period; each rise lands just after a tick edge
    task automatic spi_byte(input logic [7:0] b, output logic [7:0] r);
        align();
        for (int i = 7; i >= 0; i--) begin
            mosi = b[i];
            repeat (12) @(negedge clk);
            r[i] = miso;
            sclk = 1'b1;
            if (i == 0) begin
                repeat (6) @(negedge clk);
                commit();
                repeat (6) @(negedge clk);
            end else begin
                repeat (12) @(negedge clk);
            end
            sclk = 1'b0;
        end
    endtask

    task automatic xfer(input logic [7:0] q[$], output logic [7:0] rb[$]);
        logic [7:0] r;
        logic [7:0] c0;
        logic [7:0] lo;
        int ch;
        bit wr;
        bit sl;
        rb = {};
        ch = 0;
        wr = 1'b0;
        sl = 1'b0;
        lo = 8'h00;
        ss = 1'b0;
        repeat (4) @(negedge clk);
        for (int k = 0; k < q.size(); k++) begin
            if (k == 0) begin
                c0 = q[0];
                ch = int'(c0[3:0]);
                sl = c0[4];
                wr = c0[5];
            end else if (k % 2 == 1) begin
                lo = q[k];
            end else if (wr) begin
                if (ch == 0) begin
                    pend     = 1'b1;
                    pend_sel = sl;
                    pend_val = {q[k], lo};
                end
                ch++;
            end
            spi_byte(q[k], r);
            rb.push_back(r);
        end
        repeat (12) @(negedge clk);
        ss = 1'b1;
        repeat (24) @(negedge clk);
    endtask

    task automatic read_chk(input logic [7:0] cmd, input int n, input string name);
        int val;
        logic [7:0] e;
        logic [7:0] q[$];
        logic [7:0] r[$];
        val = (cmd[3:0] != 4'd0) ? 0 : (cmd[4] ? m_duty : m_freq);
        q = {cmd};
        for (int k = 1; k < n; k++) q.push_back(8'h00);
        xfer(q, r);
        for (int k = 1; k < n; k++) begin
            e = (k % 2 == 1) ? val[7:0] : val[15:8];
            chk(name, int'(r[k]), int'(e));
        end
        rxq = r;
    endtask

    task automatic write_chk(input logic [7:0] cmd, input logic [15:0] v, input string name);
        logic [7:0] q[$];
        logic [7:0] r[$];
        q = {cmd, v[7:0], v[15:8]};
        xfer(q, r);
        chk(name, int'(r[1]), 0);
        chk(name, int'(r[2]), 0);
    endtask

    task automatic count_high(input int n, output int c);
        c = 0;
        repeat (n) begin
            @(negedge clk);
            if (pwm_pin) c++;
        end
    endtask

    initial begin
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_pin", int'(pwm_pin), 0);
        chk("reset_miso", int'(miso), 0);
        rst = 1'b0;
        cmp_en = 1'b1;

        read_chk(8'h00, 3, "rd_freq_reset");
        chk("rd_freq_lo_lit", int'(rxq[1]), 8'h90);
        chk("rd_freq_hi_lit", int'(rxq[2]), 8'h01);
        read_chk(8'h10, 3, "rd_duty_reset");
        chk("rd_duty_lit", int'({rxq[2], rxq[1]}), 0);

        // duty 1000 us at 400 Hz: 12000 high of every 30000 clocks
        write_chk(8'h30, 16'd1000, "wr_duty_miso");
        count_high(30000, cnt);
        chk("duty1000_high_clks", cnt, 12000);

        write_chk(8'h20, 16'd1000, "wr_freq_miso");
        write_chk(8'h30, 16'd1500, "wr_duty_miso");
        repeat (12100) @(negedge clk);
        count_high(2400, cnt);
        chk("duty_gt_period_high", cnt, 2400);

        // asynchronous reset while the pin is high
        #2;
        rst = 1'b1;
        m_freq = 400;
        m_duty = 0;
        #1;
        chk("async_rst_pin", int'(pwm_pin), 0);
        chk("async_rst_miso", int'(miso), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        read_chk(8'h00, 3, "rd_freq_after_rst");
        chk("rd_freq_after_rst_lit", int'({rxq[2], rxq[1]}), 400);

        write_chk(8'h30, 16'h1234, "wr_duty_miso");
        read_chk(8'h10, 4, "rd_duty_repeat");
        chk("rd_b1_lit", int'(rxq[1]), 8'h34);
        chk("rd_b2_lit", int'(rxq[2]), 8'h12);
        chk("rd_b3_lit", int'(rxq[3]), 8'h34);

        // aborted pair must not reach the register
        txq = {8'h30, 8'h55};
        xfer(txq, rxq);
        read_chk(8'h10, 3, "rd_duty_after_abort");
        chk("abort_duty_lit", int'({rxq[2], rxq[1]}), 16'h1234);
        write_chk(8'h20, 16'd2000, "wr_freq_miso");
        read_chk(8'h00, 3, "rd_freq_2000");
        chk("freq2000_lit", int'({rxq[2], rxq[1]}), 2000);

        write_chk(8'h31, 16'hFFFF, "wr_ch1_miso");
        read_chk(8'h10, 3, "rd_duty_after_ch1");
        chk("ch1_duty_lit", int'({rxq[2], rxq[1]}), 16'h1234);
        read_chk(8'h11, 3, "rd_ch1");
        chk("rd_ch1_lit", int'({rxq[2], rxq[1]}), 0);

        write_chk(8'h30, 16'd0, "wr_duty_miso");
        count_high(2400, cnt);
        chk("duty0_high", cnt, 0);

        write_chk(8'h30, 16'd100, "wr_duty_miso");
        write_chk(8'h20, 16'd0, "wr_freq_miso");
        count_high(2400, cnt);
        chk("freq0_high", cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
